// File: rtl/result_collector.sv
// result_collector: gathers the four accumulator words of each 2x2 output
// tile into a small FIFO and streams them out as c11, c12, c21, c22.
// A run is framed by start (IDLE->COLLECT) and done_in (COLLECT->DRAIN);
// done pulses once the FIFO has emptied. Bad pushes are dropped whole and
// latch err.
module result_collector #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        push11,
  input  logic        pushedge,
  input  logic        push22,
  input  logic        done_in,
  input  logic [31:0] c11,
  input  logic [31:0] c12,
  input  logic [31:0] c21,
  input  logic [31:0] c22,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] tile_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

  state_t         state, state_nxt;
  logic [1:0]     rst_sync;
  logic           rst_n;
  logic [31:0]    mem [DEPTH];
  logic [AW-1:0]  wptr, rptr;
  logic [CW-1:0]  count, need, free, wr_n;
  logic [1:0]     n_push;
  logic           rd, wr_ok, set_err, clear_run;

  // Reset asserts immediately but releases only after two clk edges.
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) rst_sync <= 2'b00;
    else          rst_sync <= {rst_sync[0], 1'b1};

  assign rst_n = rst_sync[1];

  // Push decode. Free space is taken before this cycle's read, so a full-ish
  // FIFO only accepts what fits without relying on the concurrent pop.
  assign n_push    = 2'(push11) + 2'(pushedge) + 2'(push22);
  assign need      = pushedge ? CW'(2) : CW'(1);
  assign free      = DEPTH_C - count;
  assign wr_ok     = (state == COLLECT) && (n_push == 2'd1) && (need <= free);
  assign wr_n      = wr_ok ? need : '0;
  assign set_err   = ((state == COLLECT) && (n_push != 2'd0) && !wr_ok) ||
                     ((state == DRAIN) && (n_push != 2'd0));
  assign clear_run = (state == IDLE) && start;

  assign out_valid = (count != '0);
  assign rd        = out_valid && out_ready;
  assign out_data  = out_valid ? mem[rptr] : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  // Next state and run-status outputs.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:    if (start) state_nxt = COLLECT;
      COLLECT: begin
        busy = 1'b1;
        if (done_in) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (count == '0) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO storage; pushedge lands c12 ahead of c21.
  always_ff @(posedge clk)
    if (wr_ok) begin
      if (push11)   mem[wptr] <= c11;
      if (push22)   mem[wptr] <= c22;
      if (pushedge) begin
        mem[wptr]              <= c12;
        mem[AW'(wptr + 1'b1)]  <= c21;
      end
    end

  // Pointers, occupancy, error flag and tile counter.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      err        <= 1'b0;
      tile_count <= '0;
    end else begin
      wptr  <= wptr + AW'(wr_n);
      rptr  <= rptr + AW'(rd);
      count <= count + wr_n - CW'(rd);
      if (clear_run)    err <= 1'b0;
      else if (set_err) err <= 1'b1;
      if (clear_run)              tile_count <= '0;
      else if (wr_ok && push22)   tile_count <= tile_count + 32'd1;
    end

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: each task drives one scenario and
// checks outputs on the falling edge against hand-computed values.
module tb_result_collector;
  localparam int DEPTH = 8;

  logic        clk = 1'b0, reset_n = 1'b0, start = 1'b0, done_in = 1'b0;
  logic        push11 = 1'b0, pushedge = 1'b0, push22 = 1'b0, out_ready = 1'b0;
  logic [31:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
  logic [31:0] out_data, tile_count;
  logic        out_valid, busy, done, err;
  int total = 0, bad = 0;

  result_collector #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .push11(push11),
    .pushedge(pushedge), .push22(push22), .done_in(done_in),
    .c11(c11), .c12(c12), .c21(c21), .c22(c22),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .err(err), .tile_count(tile_count));

  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic a, input logic b, input logic c,
                      input logic [31:0] v11, input logic [31:0] v12,
                      input logic [31:0] v21, input logic [31:0] v22);
    push11 = a; pushedge = b; push22 = c;
    c11 = v11; c12 = v12; c21 = v21; c22 = v22;
    step();
    push11 = 1'b0; pushedge = 1'b0; push22 = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  // Ends a run and waits (bounded) for done; returns one cycle later in IDLE.
  task automatic finish_run();
    int n;
    out_ready = 1'b1;
    done_in = 1'b1; step(); done_in = 1'b0;
    for (n = 0; n < 40 && !done; n++) step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL finish_done got=%b want=1", done); end
    step();
  endtask

  task automatic test_reset();
    step();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data got=%h want=0", out_data); end
    total++; if (tile_count !== 32'h0) begin bad++; $display("FAIL rst_tiles got=%0d want=0", tile_count); end
    reset_n = 1'b1;
    step(); step(); step();
  endtask

  task automatic test_single_tile();
    out_ready = 1'b1;
    pulse_start();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL st_busy got=%b want=1", busy); end
    push(1'b1, 1'b0, 1'b0, 32'd1, 0, 0, 0);
    total++; if (out_valid !== 1'b1 || out_data !== 32'd1) begin bad++; $display("FAIL st_w0 got=%h want=1", out_data); end
    push(1'b0, 1'b1, 1'b0, 0, 32'd2, 32'd3, 0);
    total++; if (out_data !== 32'd2) begin bad++; $display("FAIL st_w1 got=%h want=2", out_data); end
    push(1'b0, 1'b0, 1'b1, 0, 0, 0, 32'hFFFFFFFC);
    total++; if (out_data !== 32'd3) begin bad++; $display("FAIL st_w2 got=%h want=3", out_data); end
    total++; if (tile_count !== 32'd1) begin bad++; $display("FAIL st_tiles got=%0d want=1", tile_count); end
    done_in = 1'b1; step(); done_in = 1'b0;
    total++; if (out_data !== 32'hFFFFFFFC) begin bad++; $display("FAIL st_w3 got=%h want=fffffffc", out_data); end
    step();
    total++; if (out_valid !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL st_drain got=%b%b want=00", out_valid, done); end
    step();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL st_done got=%b want=1", done); end
    step();
    total++; if (done !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL st_idle got=%b%b want=00", done, busy); end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp [8];
    exp = '{32'd11, 32'd12, 32'd13, 32'd14, 32'd21, 32'd22, 32'd23, 32'd24};
    out_ready = 1'b0;
    pulse_start();
    push(1'b1, 1'b0, 1'b0, 32'd11, 0, 0, 0);
    push(1'b0, 1'b1, 1'b0, 0, 32'd12, 32'd13, 0);
    push(1'b0, 1'b0, 1'b1, 0, 0, 0, 32'd14);
    push(1'b1, 1'b0, 1'b0, 32'd21, 0, 0, 0);
    push(1'b0, 1'b1, 1'b0, 0, 32'd22, 32'd23, 0);
    push(1'b0, 1'b0, 1'b1, 0, 0, 0, 32'd24);
    total++; if (err !== 1'b0 || out_data !== 32'd11) begin bad++; $display("FAIL bp_full got=%b/%h want=0/b", err, out_data); end
    push(1'b1, 1'b0, 1'b0, 32'd31, 0, 0, 0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL bp_ovf got=%b want=1", err); end
    push(1'b0, 1'b1, 1'b0, 0, 32'd32, 32'd33, 0);
    push(1'b0, 1'b0, 1'b1, 0, 0, 0, 32'd34);
    total++; if (tile_count !== 32'd2) begin bad++; $display("FAIL bp_tiles got=%0d want=2", tile_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin bad++; $display("FAIL bp_word%0d got=%h want=%h", i, out_data, exp[i]); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    finish_run();
  endtask

  task automatic test_edge_full();
    logic [31:0] exp [7];
    exp = '{32'd42, 32'd43, 32'd44, 32'd45, 32'd46, 32'd47, 32'd50};
    out_ready = 1'b0;
    pulse_start();
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ef_clr got=%b want=0", err); end
    push(1'b1, 1'b0, 1'b0, 32'd41, 0, 0, 0);
    push(1'b0, 1'b1, 1'b0, 0, 32'd42, 32'd43, 0);
    push(1'b0, 1'b0, 1'b1, 0, 0, 0, 32'd44);
    push(1'b1, 1'b0, 1'b0, 32'd45, 0, 0, 0);
    push(1'b0, 1'b1, 1'b0, 0, 32'd46, 32'd47, 0);
    total++; if (err !== 1'b0) begin bad++; $display("FAIL ef_seven got=%b want=0", err); end
    push(1'b0, 1'b1, 1'b0, 0, 32'd48, 32'd49, 0);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL ef_drop got=%b want=1", err); end
    out_ready = 1'b1;
    push(1'b1, 1'b0, 1'b0, 32'd50, 0, 0, 0);
    out_ready = 1'b0;
    step();
    total++; if (out_data !== 32'd42) begin bad++; $display("FAIL ef_hold got=%h want=2a", out_data); end
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin bad++; $display("FAIL ef_word%0d got=%h want=%h", i, out_data, exp[i]); end
      step();
    end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL ef_empty got=%b want=0", out_valid); end
    finish_run();
  endtask

  task automatic test_protocol();
    out_ready = 1'b1;
    pulse_start();
    push(1'b1, 1'b0, 1'b1, 32'd5, 0, 0, 32'd6);
    total++; if (err !== 1'b1) begin bad++; $display("FAIL pr_multi_err got=%b want=1", err); end
    total++; if (out_valid !== 1'b0 || tile_count !== 32'd0) begin bad++; $display("FAIL pr_multi_nowr got=%b/%0d want=0/0", out_valid, tile_count); end
    finish_run();
    out_ready = 1'b0;
    pulse_start();
    push(1'b1, 1'b0, 1'b0, 32'd7, 0, 0, 0);
    done_in = 1'b1; step(); done_in = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL pr_pre got=%b want=0", err); end
    push(1'b0, 1'b0, 1'b1, 0, 0, 0, 32'd9);
    total++; if (err !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL pr_drain_err got=%b/%b want=1/1", err, busy); end
    total++; if (tile_count !== 32'd0 || out_data !== 32'd7) begin bad++; $display("FAIL pr_drain_nowr got=%0d/%h want=0/7", tile_count, out_data); end
    finish_run();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    pulse_start();
    push(1'b1, 1'b0, 1'b0, 32'd61, 0, 0, 0);
    push(1'b0, 1'b1, 1'b0, 0, 32'd62, 32'd63, 0);
    push(1'b0, 1'b0, 1'b1, 0, 0, 0, 32'd64);
    step(); step();
    out_ready = 1'b0;
    push(1'b1, 1'b0, 1'b0, 32'd65, 0, 0, 0);
    push(1'b0, 1'b1, 1'b0, 0, 32'd66, 32'd67, 0);
    total++; if (out_valid !== 1'b1 || tile_count !== 32'd1) begin bad++; $display("FAIL rm_pre got=%b/%0d want=1/1", out_valid, tile_count); end
    #2 reset_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0 || tile_count !== 32'd0) begin bad++; $display("FAIL rm_async got=%b/%0d want=0/0", out_valid, tile_count); end
    total++; if (busy !== 1'b0 || out_data !== 32'd0) begin bad++; $display("FAIL rm_busy got=%b/%h want=0/0", busy, out_data); end
    step(); step();
    reset_n = 1'b1;
    step(); step(); step();
    push(1'b1, 1'b0, 1'b0, 32'd70, 0, 0, 0);
    step();
    total++; if (out_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rm_nostart got=%b/%b want=0/0", out_valid, busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp [4];
    exp = '{32'd91, 32'd92, 32'd93, 32'd94};
    out_ready = 1'b0;
    pulse_start();
    push(1'b1, 1'b0, 1'b0, 32'd81, 0, 0, 0);
    push(1'b0, 1'b1, 1'b0, 0, 32'd82, 32'd83, 0);
    push(1'b0, 1'b0, 1'b1, 0, 0, 0, 32'd84);
    push(1'b1, 1'b1, 1'b0, 32'd85, 32'd86, 32'd87, 0);
    finish_run();
    total++; if (err !== 1'b1 || tile_count !== 32'd1) begin bad++; $display("FAIL bb_prev got=%b/%0d want=1/1", err, tile_count); end
    out_ready = 1'b0;
    pulse_start();
    total++; if (err !== 1'b0 || tile_count !== 32'd0 || busy !== 1'b1) begin bad++; $display("FAIL bb_clear got=%b/%0d/%b want=0/0/1", err, tile_count, busy); end
    push(1'b1, 1'b0, 1'b0, 32'd91, 0, 0, 0);
    push(1'b0, 1'b1, 1'b0, 0, 32'd92, 32'd93, 0);
    push(1'b0, 1'b0, 1'b1, 0, 0, 0, 32'd94);
    total++; if (err !== 1'b0 || tile_count !== 32'd1) begin bad++; $display("FAIL bb_run2 got=%b/%0d want=0/1", err, tile_count); end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== exp[i]) begin bad++; $display("FAIL bb_word%0d got=%h want=%h", i, out_data, exp[i]); end
      step();
    end
    finish_run();
  endtask

  initial begin
    test_reset();
    test_single_tile();
    test_backpressure();
    test_edge_full();
    test_protocol();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 SHALL have parameter DEPTH, default 8, output FIFO depth in 32-bit words; power of two, minimum 4.
REQ-002 SHALL have one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, one-cycle pulse that begins a collection run.
REQ-006 SHALL have port push11, input, 1, pulse meaning c11 is final.
REQ-007 SHALL have port pushedge, input, 1, pulse meaning c12 and c21 are final.
REQ-008 SHALL have port push22, input, 1, pulse meaning c22 is final.
REQ-009 SHALL have port done_in, input, 1, pulse meaning the feeder has finished all tiles.
REQ-010 SHALL have ports c11, c12, c21, c22, input, 32 each, signed PE accumulator values.
REQ-011 SHALL have port out_data, output, 32, FIFO head word.
REQ-012 SHALL have port out_valid, output, 1, meaning out_data holds a word.
REQ-013 SHALL have port out_ready, input, 1, consumer accept signal.
REQ-014 SHALL have port busy, output, 1, high in COLLECT and DRAIN.
REQ-015 SHALL have port done, output, 1, one-cycle pulse when the run is complete and the FIFO is empty.
REQ-016 SHALL have port err, output, 1, sticky flag for overflow or protocol violation.
REQ-017 SHALL have port tile_count, output, 32, number of complete 2x2 tiles accepted.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, DRAIN and DONE.
REQ-019 SHALL move IDLE->COLLECT on start, and in that same transition clear tile_count and err.
REQ-020 SHALL move COLLECT->DRAIN on done_in.
REQ-021 SHALL move DRAIN->DONE when the FIFO count is 0.
REQ-022 SHALL move DONE->IDLE unconditionally; done SHALL be high only in DONE.
REQ-023 SHALL ignore push and done_in pulses outside COLLECT, except that a push in DRAIN SHALL set err.
REQ-024 SHALL ignore start outside IDLE.
REQ-025 SHALL, on push11 in COLLECT, write c11 as 1 word.
REQ-026 SHALL, on pushedge in COLLECT, write c12 then c21 (c12 first out) as 2 words in one cycle.
REQ-027 SHALL, on push22 in COLLECT, write c22 as 1 word and increment tile_count by 1 (wraps at 2^32).
REQ-028 SHALL, as a result, emit words per tile in order c11, c12, c21, c22.
REQ-029 SHALL, when more than one push is high in the same cycle, write nothing, leave tile_count unchanged and set err.
REQ-030 SHALL, when free space is less than the words required, drop the whole push (no partial write), leave tile_count unchanged and set err.
REQ-031 SHALL, with a simultaneous read and write, compute the new count as count + writes - read; space for the check is computed before that cycle's read.
REQ-032 SHALL drive out_valid = (count != 0); a read occurs when out_valid and out_ready are both high.
REQ-033 SHALL hold out_data and out_valid stable while out_valid is high and out_ready is low.
REQ-034 SHALL have latency of one cycle: a word written at edge N appears on out_data after edge N when the FIFO was empty.
REQ-035 SHALL wrap read and write pointers modulo DEPTH and pass data unmodified (no saturation or rounding).
REQ-036 SHALL accept a push coincident with done_in before entering DRAIN.

Reset
REQ-037 SHALL, on reset_n low, asynchronously set state to IDLE, FIFO count and pointers to 0, and out_valid, busy, done, err to 0, out_data to 0 and tile_count to 0.
REQ-038 SHALL, on reset mid-run, discard FIFO contents; no words are emitted after release until a new start.
REQ-039 SHALL release reset synchronously to clk.

Verification
REQ-040 SHALL cover single tile: start; push11 (c11=1), pushedge (c12=2, c21=3), push22 (c22=-4), done_in; out_ready=1 -> out_data 1,2,3,0xFFFFFFFC on consecutive cycles, tile_count=1, done pulses once after the last read.
REQ-041 SHALL cover backpressure: out_ready=0 over 2 tiles (8 words, DEPTH=8) -> count 8, err=0; a third push11 -> err=1, tile 3 words absent; then out_ready=1 -> the 8 words drain in order.
REQ-042 SHALL cover the edge-full case: count=7 and pushedge -> dropped, err=1; with count=7, a push11 and simultaneous read -> accepted, count stays 7.
REQ-043 SHALL cover protocol errors: push11 and push22 in the same cycle -> no write, err=1, tile_count unchanged; a push during DRAIN -> err=1.
REQ-044 SHALL cover reset mid-run: reset_n low with 3 words queued -> out_valid=0, tile_count=0 immediately; after release and no start, a push11 -> no write.
REQ-045 SHALL cover back-to-back runs: done, then start the next cycle -> err and tile_count cleared, the second run is collected correctly.
